// File: rtl/frame_cfg_pkg.sv
// frame_cfg_pkg: shared status-FSM state type and frame-index width helper
package frame_cfg_pkg;

    typedef enum logic [1:0] {EMPTY, DIRTY, CLEAN} cfgState_t;

    function automatic int frameIdxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_config_mem_if.sv
// frame_config_mem_if: frame load / config output bus; readback signals exist only with FRAME_READBACK_EN
interface frame_config_mem_if #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 20
);
    import frame_cfg_pkg::*;

    localparam int IdxW = frameIdxWidth(MaxFramesPerCol);

    logic [FrameBitsPerRow-1:0] FrameData;
    logic [MaxFramesPerCol-1:0] FrameStrobe;
    logic                       commit;
    logic [NoConfigBits-1:0]    ConfigBits;
    logic [NoConfigBits-1:0]    ConfigBits_N;
    logic                       cfg_valid;
    logic                       cfg_dirty;
`ifdef FRAME_READBACK_EN
    logic                       rb_req;
    logic [IdxW-1:0]            rb_frame;
    logic                       rb_ack;
    logic [FrameBitsPerRow-1:0] rb_data;
    logic                       rb_err;
`endif

    modport master (
        output FrameData, FrameStrobe, commit,
`ifdef FRAME_READBACK_EN
        output rb_req, rb_frame,
        input  rb_ack, rb_data, rb_err,
`endif
        input  ConfigBits, ConfigBits_N, cfg_valid, cfg_dirty
    );

    modport slave (
        input  FrameData, FrameStrobe, commit,
`ifdef FRAME_READBACK_EN
        input  rb_req, rb_frame,
        output rb_ack, rb_data, rb_err,
`endif
        output ConfigBits, ConfigBits_N, cfg_valid, cfg_dirty
    );

endinterface

// File: rtl/frame_cfg_frame.sv
// frame_cfg_frame: shadow storage for the mapped bits of one frame, captured on its strobe
module frame_cfg_frame #(
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 20,
    parameter int MappedBits      = 20,
    parameter int Offset          = 0
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic                       strobe,
    input  logic [MappedBits-1:0]      frameData,
    output logic [NoConfigBits-1:0]    shadowBits,
    output logic [FrameBitsPerRow-1:0] frameWord
);

    logic [MappedBits-1:0] bits;

    // capture the MSB-aligned mapped slice of the frame word on strobe
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) bits <= '0;
        else if (strobe) bits <= frameData;
    end

    assign shadowBits = NoConfigBits'(bits) << Offset;
    assign frameWord  = FrameBitsPerRow'(bits) << (FrameBitsPerRow - MappedBits);

endmodule

// File: rtl/frame_config_mem.sv
// frame_config_mem: double-buffered frame config memory (shadow + active); optional readback via FRAME_READBACK_EN
module frame_config_mem
    import frame_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NoConfigBits    = 20
) (
    input logic               CLK,
    input logic               resetn,
    frame_config_mem_if.slave bus
);

    logic [NoConfigBits-1:0]    shadowPart [MaxFramesPerCol];
    logic [FrameBitsPerRow-1:0] frameWord  [MaxFramesPerCol];
    logic [NoConfigBits-1:0]    shadow;
    logic [NoConfigBits-1:0]    active;
    logic                       anyStrobe;
    logic                       cfgValid;
    logic                       cfgDirty;
    cfgState_t                  state;
    logic                       unusedFrameData;

    // frame f holds config positions p = f*W .. f*W+W-1 that fall below NoConfigBits
    for (genvar f = 0; f < MaxFramesPerCol; f++) begin : g_frame
        localparam int Base = f * FrameBitsPerRow;
        if (Base < NoConfigBits) begin : g_map
            localparam int Cnt = (NoConfigBits - Base < FrameBitsPerRow) ? NoConfigBits - Base : FrameBitsPerRow;
            frame_cfg_frame #(
                .FrameBitsPerRow(FrameBitsPerRow),
                .NoConfigBits   (NoConfigBits),
                .MappedBits     (Cnt),
                .Offset         (NoConfigBits - Base - Cnt)
            ) u_frame (
                .CLK       (CLK),
                .resetn    (resetn),
                .strobe    (bus.FrameStrobe[f]),
                .frameData (bus.FrameData[FrameBitsPerRow-1 -: Cnt]),
                .shadowBits(shadowPart[f]),
                .frameWord (frameWord[f])
            );
        end else begin : g_unmapped
            assign shadowPart[f] = '0;
            assign frameWord[f]  = '0;
        end
    end

    // merge the disjoint per-frame slices into the full shadow image
    always_comb begin
        shadow = '0;
        for (int i = 0; i < MaxFramesPerCol; i++) shadow |= shadowPart[i];
    end

    assign anyStrobe       = |bus.FrameStrobe;
    assign unusedFrameData = ^bus.FrameData;

    // active image loads the pre-edge shadow on commit
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) active <= '0;
        else if (bus.commit) active <= shadow;
    end

    // status FSM: a strobe always wins to DIRTY, a lone commit goes CLEAN
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state    <= EMPTY;
            cfgValid <= 1'b0;
            cfgDirty <= 1'b0;
        end else begin
            if (anyStrobe) begin
                state    <= DIRTY;
                cfgDirty <= 1'b1;
            end else if (bus.commit) begin
                state    <= CLEAN;
                cfgDirty <= 1'b0;
            end else begin
                state    <= state;
            end
            if (bus.commit) cfgValid <= 1'b1;
        end
    end

    assign bus.ConfigBits   = active;
    assign bus.ConfigBits_N = ~active;
    assign bus.cfg_valid    = cfgValid;
    assign bus.cfg_dirty    = cfgDirty;

`ifdef FRAME_READBACK_EN
    localparam int IdxW = frameIdxWidth(MaxFramesPerCol);

    logic [FrameBitsPerRow-1:0] rbWord;
    logic                       rbHit;
    logic                       rbAck;
    logic                       rbErr;
    logic [FrameBitsPerRow-1:0] rbData;

    // select the requested frame; an index past the last frame is a miss
    always_comb begin
        rbWord = '0;
        rbHit  = 1'b0;
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            if (bus.rb_frame == IdxW'(i)) begin
                rbWord = frameWord[i];
                rbHit  = 1'b1;
            end
        end
    end

    // one ack per sampled request, carrying pre-edge shadow data
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            rbAck  <= 1'b0;
            rbErr  <= 1'b0;
            rbData <= '0;
        end else begin
            rbAck  <= bus.rb_req;
            rbErr  <= bus.rb_req & ~rbHit;
            rbData <= (bus.rb_req & rbHit) ? rbWord : '0;
        end
    end

    assign bus.rb_ack  = rbAck;
    assign bus.rb_err  = rbErr;
    assign bus.rb_data = rbData;
`endif

endmodule
